// File: rtl/sd_pkg.sv
// sd_pkg: shared constants and types for the SD card SPI-mode blocks.
//   - SPI command/token byte values used by the block reader
//   - error codes reported alongside sd_err
//   - state encoding of the block-read FSM
//   - cmd17_byte(): byte k (1..6) of a CMD17 frame for a given block address
package sd_pkg;

  localparam logic [7:0] CMD17       = 8'h51;
  localparam logic [7:0] TOKEN_START = 8'hFE;
  localparam logic [7:0] DUMMY       = 8'hFF;

  localparam logic [1:0] ERR_R1_TIMEOUT = 2'd0;
  localparam logic [1:0] ERR_R1_NONZERO = 2'd1;
  localparam logic [1:0] ERR_TOKEN      = 2'd2;
  localparam logic [1:0] ERR_NOT_INIT   = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_R1,
    ST_TOKEN,
    ST_DATA,
    ST_CRC,
    ST_END,
    ST_DONE,
    ST_ERR,
    ST_FAIL
  } rd_state_t;

  // Index 0 is the chip-select-high dummy byte; 1..6 form the command frame.
  // The trailing CRC byte is 0xFF because SPI mode ignores CRC on CMD17.
  function automatic logic [7:0] cmd17_byte(input logic [2:0] idx, input logic [31:0] addr);
    logic [7:0] b;
    case (idx)
      3'd1:    b = CMD17;
      3'd2:    b = addr[31:24];
      3'd3:    b = addr[23:16];
      3'd4:    b = addr[15:8];
      3'd5:    b = addr[7:0];
      default: b = DUMMY;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sd_spi_byte.sv
// sd_spi_byte: one full-duplex SPI mode-0 byte transfer, MSB first.
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   start      begin a byte (ignored while a byte is in flight)
//   tx[7:0]    byte to shift out on sd_mosi
//   sd_miso    serial data from the card, sampled on sd_ck rising
//   rx[7:0]    received byte, complete when done pulses
//   done       1-cycle pulse at the final sd_ck falling edge of the byte
//   sd_ck      SPI clock, idles low, CLK_DIV clk per half-period
//   sd_mosi    serial data to the card, updated on sd_ck falling, idles high
// A byte lasts exactly 16*CLK_DIV clk from the start cycle to done.
module sd_spi_byte #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic       sd_miso,
  output logic [7:0] rx,
  output logic       done,
  output logic       sd_ck,
  output logic       sd_mosi
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic             run;
  logic [DIV_W-1:0] div;
  logic [3:0]       edge_cnt;
  logic [7:0]       tx_sh;
  logic [7:0]       rx_sh;

  // Shift engine: the first bit is placed on MOSI at start so it is set up
  // a full half-period before the first rising edge. Even edges rise and
  // sample MISO, odd edges fall and advance MOSI; edge 15 ends the byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run      <= 1'b0;
      div      <= '0;
      edge_cnt <= 4'd0;
      tx_sh    <= 8'hFF;
      rx_sh    <= 8'h00;
      sd_ck    <= 1'b0;
      sd_mosi  <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!run) begin
        if (start) begin
          run      <= 1'b1;
          div      <= '0;
          edge_cnt <= 4'd0;
          tx_sh    <= tx;
          sd_mosi  <= tx[7];
        end
      end else if (div == DIV_MAX) begin
        div      <= '0;
        edge_cnt <= edge_cnt + 4'd1;
        if (!sd_ck) begin
          sd_ck <= 1'b1;
          rx_sh <= {rx_sh[6:0], sd_miso};
        end else begin
          sd_ck <= 1'b0;
          if (edge_cnt == 4'd15) begin
            run     <= 1'b0;
            done    <= 1'b1;
            sd_mosi <= 1'b1;
          end else begin
            tx_sh   <= {tx_sh[6:0], 1'b1};
            sd_mosi <= tx_sh[6];
          end
        end
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  assign rx = rx_sh;

endmodule

// File: rtl/sd_block_read.sv
// sd_block_read: SPI-mode single-block (CMD17) reader for an initialised SD card.
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   init_ok       card initialised; requests without it fail with err_code 3
//   sd_ren        1-cycle read request, accepted only when idle
//   sd_addr[31:0] block address, latched on accept
//   busy          high from accept through the done/error pulse
//   sd_ck, sd_mosi, sd_csn, sd_miso   SPI mode-0 bus to the card
//   rd_data[7:0], rd_valid, rd_ready  payload byte stream, held until accepted
//   sd_read_ok    1-cycle pulse when the whole block has been delivered
//   sd_err        1-cycle pulse on abort, err_code[1:0] gives the reason
module sd_block_read
  import sd_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int BLOCK_BYTES = 512,
  parameter int R1_TRIES    = 8,
  parameter int TOK_TRIES   = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_ok,
  input  logic        sd_ren,
  input  logic [31:0] sd_addr,
  output logic        busy,
  output logic        sd_ck,
  output logic        sd_mosi,
  output logic        sd_csn,
  input  logic        sd_miso,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        sd_read_ok,
  output logic        sd_err,
  output logic [1:0]  err_code
);

  localparam int POLL_MAX = (TOK_TRIES > R1_TRIES) ? TOK_TRIES : R1_TRIES;
  localparam int POLL_W   = $clog2(POLL_MAX + 1);
  localparam logic [POLL_W-1:0] R1_LAST   = POLL_W'(R1_TRIES - 1);
  localparam logic [POLL_W-1:0] TOK_LAST  = POLL_W'(TOK_TRIES - 1);
  localparam logic [POLL_W-1:0] POLL_SAT  = POLL_W'(POLL_MAX);
  localparam logic [9:0]        BLOCK_LAST = 10'(BLOCK_BYTES - 1);

  rd_state_t          state, state_n;
  logic [9:0]         cnt;
  logic [POLL_W-1:0]  poll_cnt;
  logic [31:0]        addr_q;
  logic [1:0]         err_q, err_n;
  logic               csn_q;
  logic [7:0]         rd_data_q;
  logic               rd_valid_q;
  logic               active_q;

  logic               spi_start;
  logic [7:0]         spi_tx;
  logic [7:0]         spi_rx;
  logic               spi_done;

  sd_spi_byte #(.CLK_DIV(CLK_DIV)) u_spi (
    .clk     (clk),
    .rst     (rst),
    .start   (spi_start),
    .tx      (spi_tx),
    .sd_miso (sd_miso),
    .rx      (spi_rx),
    .done    (spi_done),
    .sd_ck   (sd_ck),
    .sd_mosi (sd_mosi)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next state, byte-engine control and error reason. A new SPI byte starts
  // only once the previous one has fully finished (active_q low), and in DATA
  // also only once the consumer has taken the pending byte, so the SPI clock
  // simply stays low while the consumer stalls.
  always_comb begin
    state_n   = state;
    err_n     = err_q;
    spi_start = 1'b0;
    spi_tx    = DUMMY;
    case (state)
      ST_IDLE: begin
        if (sd_ren) begin
          if (init_ok) begin
            state_n = ST_CMD;
          end else begin
            state_n = ST_FAIL;
            err_n   = ERR_NOT_INIT;
          end
        end
      end
      ST_CMD: begin
        spi_tx    = cmd17_byte(cnt[2:0], addr_q);
        spi_start = !active_q;
        if (spi_done && cnt == 10'd6) state_n = ST_R1;
      end
      ST_R1: begin
        spi_start = !active_q;
        if (spi_done) begin
          if (!spi_rx[7]) begin
            if (spi_rx == 8'h00) begin
              state_n = ST_TOKEN;
            end else begin
              state_n = ST_ERR;
              err_n   = ERR_R1_NONZERO;
            end
          end else if (poll_cnt == R1_LAST) begin
            state_n = ST_ERR;
            err_n   = ERR_R1_TIMEOUT;
          end
        end
      end
      ST_TOKEN: begin
        spi_start = !active_q;
        if (spi_done) begin
          if (spi_rx == TOKEN_START) begin
            state_n = ST_DATA;
          end else if (spi_rx != DUMMY || poll_cnt == TOK_LAST) begin
            state_n = ST_ERR;
            err_n   = ERR_TOKEN;
          end
        end
      end
      ST_DATA: begin
        spi_start = !active_q && !rd_valid_q;
        if (rd_valid_q && rd_ready && cnt == BLOCK_LAST) state_n = ST_CRC;
      end
      ST_CRC: begin
        spi_start = !active_q;
        if (spi_done && cnt == 10'd1) state_n = ST_END;
      end
      ST_END: begin
        spi_start = !active_q;
        if (spi_done) state_n = ST_DONE;
      end
      ST_DONE: state_n = ST_IDLE;
      ST_ERR: begin
        spi_start = !active_q;
        if (spi_done) state_n = ST_FAIL;
      end
      ST_FAIL: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Datapath: counters, address latch, chip select and the output byte
  // register. Both counters clear on every state change so each phase starts
  // counting from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 10'd0;
      poll_cnt   <= '0;
      addr_q     <= 32'd0;
      err_q      <= ERR_R1_TIMEOUT;
      csn_q      <= 1'b1;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      err_q <= err_n;

      if (spi_start)     active_q <= 1'b1;
      else if (spi_done) active_q <= 1'b0;

      // CS drops together with the first command byte, after the dummy byte.
      if (state_n == ST_END || state_n == ST_ERR)
        csn_q <= 1'b1;
      else if (state == ST_CMD && spi_start && cnt != 10'd0)
        csn_q <= 1'b0;

      if (rd_valid_q && rd_ready) begin
        rd_valid_q <= 1'b0;
      end else if (state == ST_DATA && spi_done) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= spi_rx;
      end

      if (state == ST_IDLE && sd_ren) addr_q <= sd_addr;

      if (state_n != state) begin
        cnt      <= 10'd0;
        poll_cnt <= '0;
      end else begin
        case (state)
          ST_CMD, ST_CRC: if (spi_done) cnt <= cnt + 10'd1;
          ST_DATA: if (rd_valid_q && rd_ready) cnt <= cnt + 10'd1;
          ST_R1, ST_TOKEN: begin
            if (spi_done && poll_cnt != POLL_SAT) poll_cnt <= poll_cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy       = (state != ST_IDLE);
  assign sd_csn     = csn_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign sd_read_ok = (state == ST_DONE);
  assign sd_err     = (state == ST_FAIL);
  assign err_code   = err_q;

endmodule

// File: tb/tb_sd_block_read.sv
// tb_sd_block_read: directed bench for sd_block_read with a behavioural SD
// card (SPI mode 0) and a byte-stream collector on the read interface.
module tb_sd_block_read;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_ok;
  logic        sd_ren;
  logic [31:0] sd_addr;
  logic        busy;
  logic        sd_ck;
  logic        sd_mosi;
  logic        sd_csn;
  logic        sd_miso;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        sd_read_ok;
  logic        sd_err;
  logic [1:0]  err_code;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Card response selector: 0 good block, 1 R1=0x04, 2 silent card, 3 no token.
  int scenario = 0;

  always #5 clk = ~clk;

  sd_block_read #(
    .CLK_DIV(2), .BLOCK_BYTES(512), .R1_TRIES(8), .TOK_TRIES(16)
  ) dut (
    .clk(clk), .rst(rst), .init_ok(init_ok), .sd_ren(sd_ren), .sd_addr(sd_addr),
    .busy(busy), .sd_ck(sd_ck), .sd_mosi(sd_mosi), .sd_csn(sd_csn), .sd_miso(sd_miso),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .sd_read_ok(sd_read_ok), .sd_err(sd_err), .err_code(err_code)
  );

  // Byte the card sends at position idx counted from the CS falling edge.
  // Positions 0..5 overlap the command frame.
  function automatic logic [7:0] resp(input int idx);
    logic [7:0] b;
    b = 8'hFF;
    case (scenario)
      0: begin
        if (idx == 8) b = 8'h00;
        else if (idx == 12) b = 8'hFE;
        else if (idx >= 13 && idx <= 524) b = 8'((idx - 13) & 255);
        else if (idx == 525) b = 8'hAB;
        else if (idx == 526) b = 8'hCD;
      end
      1: if (idx == 8) b = 8'h04;
      3: if (idx == 8) b = 8'h00;
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  logic [7:0] card_sh = 8'hFF;
  int         card_bit = 0;
  int         card_idx = 0;
  logic [7:0] mosi_sh = 8'hFF;
  int         mosi_bits = 0;
  int         mosi_cnt = 0;
  logic [7:0] mosi_log [16];
  logic       ck_q = 1'b0;
  logic       csn_m = 1'b1;
  int         csn_falls = 0;
  int         rx_count = 0;
  int         byte_errs = 0;
  int         hold_errs = 0;
  int         stall_errs = 0;
  int         ok_count = 0;
  int         err_count = 0;
  logic [1:0] last_err = 2'd0;
  bit         rd_valid_seen = 1'b0;
  bit         prev_pending = 1'b0;
  logic [7:0] prev_data = 8'h00;
  bit         clr_tog = 1'b0;
  bit         clr_seen = 1'b0;

  assign sd_miso = sd_csn ? 1'b1 : card_sh[7];

  // Card model and stream monitor, evaluated on the falling clk edge where all
  // DUT outputs are settled. The card shifts MISO after each sd_ck fall and
  // captures MOSI on each sd_ck rise, only while selected.
  always @(negedge clk) begin
    if (clr_tog != clr_seen) begin
      clr_seen = clr_tog;
      csn_falls = 0; rx_count = 0; byte_errs = 0; hold_errs = 0; stall_errs = 0;
      ok_count = 0; err_count = 0; rd_valid_seen = 1'b0; mosi_cnt = 0;
      for (int i = 0; i < 16; i++) mosi_log[i] = 8'h00;
    end
    if (csn_m && !sd_csn) begin
      card_idx = 0; card_bit = 0; card_sh = resp(0); mosi_bits = 0;
      csn_falls++;
    end else if (!sd_csn && ck_q && !sd_ck) begin
      if (card_bit == 7) begin
        card_idx++; card_bit = 0; card_sh = resp(card_idx);
      end else begin
        card_sh = {card_sh[6:0], 1'b1}; card_bit++;
      end
    end
    if (!sd_csn && !ck_q && sd_ck) begin
      mosi_sh = {mosi_sh[6:0], sd_mosi};
      mosi_bits++;
      if (mosi_bits == 8) begin
        if (mosi_cnt < 16) mosi_log[mosi_cnt] = mosi_sh;
        mosi_cnt++;
        mosi_bits = 0;
      end
    end
    ck_q  = sd_ck;
    csn_m = sd_csn;

    if (prev_pending && (!rd_valid || rd_data !== prev_data)) hold_errs++;
    if (rd_valid) begin
      rd_valid_seen = 1'b1;
      if (sd_ck) stall_errs++;
      if (rd_ready) begin
        if (rd_data !== 8'(rx_count)) byte_errs++;
        rx_count++;
      end
    end
    prev_pending = rd_valid && !rd_ready;
    prev_data    = rd_data;
    if (sd_read_ok) ok_count++;
    if (sd_err) begin
      err_count++;
      last_err = err_code;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) begin
      passes++;
    end else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr);
    @(posedge clk); #1;
    sd_addr = addr;
    sd_ren  = 1'b1;
    @(posedge clk); #1;
    sd_ren  = 1'b0;
  endtask

  task automatic clearStats();
    clr_tog = ~clr_tog;
    @(negedge clk); #1;
  endtask

  // Runs until a done or error pulse is seen, optionally randomising
  // rd_ready (~30% high) and injecting a stray sd_ren at cycle pulse_at.
  task automatic runUntilEnd(input int budget, input bit rand_rdy, input int pulse_at,
                             output bit timed_out);
    int base;
    base = ok_count + err_count;
    timed_out = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      sd_ren = (pulse_at != 0 && c == pulse_at);
      if (rand_rdy) rd_ready = ($urandom_range(0, 99) < 30);
      if (ok_count + err_count != base) begin
        timed_out = 1'b0;
        break;
      end
    end
    sd_ren   = 1'b0;
    rd_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    bit to;
    rst = 1'b1; init_ok = 1'b0; sd_ren = 1'b0; sd_addr = 32'd0; rd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_sd_ck", sd_ck, 0);
    checkOutput("reset_sd_mosi", sd_mosi, 1);
    checkOutput("reset_sd_csn", sd_csn, 1);
    checkOutput("reset_rd_valid", rd_valid, 0);
    checkOutput("reset_rd_data", rd_data, 0);
    checkOutput("reset_read_ok", sd_read_ok, 0);
    checkOutput("reset_sd_err", sd_err, 0);
    checkOutput("reset_err_code", err_code, 0);
    rst = 1'b0;
    init_ok = 1'b1;
    @(posedge clk); #1;

    $display("[TB] good block, consumer always ready");
    scenario = 0;
    clearStats();
    applyStimulus(32'h0000_1234);
    checkOutput("t1_busy_after_accept", busy, 1);
    runUntilEnd(40000, 1'b0, 0, to);
    checkOutput("t1_timeout", to, 0);
    checkOutput("t1_byte_count", rx_count, 512);
    checkOutput("t1_byte_errors", byte_errs, 0);
    checkOutput("t1_read_ok_pulses", ok_count, 1);
    checkOutput("t1_err_pulses", err_count, 0);
    checkOutput("t1_cmd_frame", {mosi_log[0], mosi_log[1], mosi_log[2], mosi_log[3],
                                 mosi_log[4], mosi_log[5]}, 48'h51_00_00_12_34_FF);
    checkOutput("t1_poll_mosi", mosi_log[6], 8'hFF);
    checkOutput("t1_busy_after", busy, 0);
    checkOutput("t1_csn_after", sd_csn, 1);

    $display("[TB] good block, random consumer stalls, stray sd_ren mid-read");
    clearStats();
    applyStimulus(32'h0000_1234);
    sd_addr = 32'hFFFF_0000;
    runUntilEnd(60000, 1'b1, 3000, to);
    checkOutput("t2_timeout", to, 0);
    checkOutput("t2_byte_count", rx_count, 512);
    checkOutput("t2_byte_errors", byte_errs, 0);
    checkOutput("t2_hold_errors", hold_errs, 0);
    checkOutput("t2_ck_during_stall", stall_errs, 0);
    checkOutput("t2_read_ok_pulses", ok_count, 1);
    checkOutput("t2_csn_falls", csn_falls, 1);
    checkOutput("t2_cmd_frame", {mosi_log[0], mosi_log[1], mosi_log[2], mosi_log[3],
                                 mosi_log[4], mosi_log[5]}, 48'h51_00_00_12_34_FF);

    $display("[TB] R1 nonzero");
    scenario = 1;
    clearStats();
    applyStimulus(32'h0000_0010);
    runUntilEnd(5000, 1'b0, 0, to);
    checkOutput("t3_timeout", to, 0);
    checkOutput("t3_err_pulses", err_count, 1);
    checkOutput("t3_err_code", last_err, 1);
    checkOutput("t3_no_rd_valid", rd_valid_seen, 0);
    checkOutput("t3_read_ok_pulses", ok_count, 0);
    checkOutput("t3_csn_after", sd_csn, 1);
    checkOutput("t3_busy_after", busy, 0);

    $display("[TB] silent card");
    scenario = 2;
    clearStats();
    applyStimulus(32'h0000_0020);
    runUntilEnd(5000, 1'b0, 0, to);
    checkOutput("t4a_timeout", to, 0);
    checkOutput("t4a_err_code", last_err, 0);
    checkOutput("t4a_card_bytes", card_idx, 14);

    $display("[TB] R1 ok but no start token");
    scenario = 3;
    clearStats();
    applyStimulus(32'h0000_0030);
    runUntilEnd(5000, 1'b0, 0, to);
    checkOutput("t4b_timeout", to, 0);
    checkOutput("t4b_err_code", last_err, 2);
    checkOutput("t4b_card_bytes", card_idx, 25);
    checkOutput("t4b_err_pulses", err_count, 1);

    $display("[TB] request without init");
    scenario = 0;
    init_ok = 1'b0;
    clearStats();
    applyStimulus(32'h0000_0040);
    checkOutput("t5_err_next_cycle", sd_err, 1);
    checkOutput("t5_err_code", err_code, 3);
    checkOutput("t5_busy_during_pulse", busy, 1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t5_busy_after", busy, 0);
    checkOutput("t5_csn_never_fell", csn_falls, 0);
    checkOutput("t5_err_pulses", err_count, 1);
    init_ok = 1'b1;

    $display("[TB] reset in the middle of the data phase");
    clearStats();
    applyStimulus(32'h0000_0077);
    to = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk); #1;
      if (rx_count >= 100) begin
        to = 1'b0;
        break;
      end
    end
    checkOutput("t6_reach_byte100", to, 0);
    rst = 1'b1;
    #1;
    checkOutput("t6_csn_on_reset", sd_csn, 1);
    checkOutput("t6_busy_on_reset", busy, 0);
    checkOutput("t6_rd_valid_on_reset", rd_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("t6_no_ok_pulse", ok_count, 0);
    checkOutput("t6_no_err_pulse", err_count, 0);
    clearStats();
    applyStimulus(32'h0000_00A5);
    runUntilEnd(40000, 1'b0, 0, to);
    checkOutput("t6_reread_timeout", to, 0);
    checkOutput("t6_reread_byte_count", rx_count, 512);
    checkOutput("t6_reread_byte_errors", byte_errs, 0);
    checkOutput("t6_reread_read_ok", ok_count, 1);
    checkOutput("t6_reread_cmd_frame", {mosi_log[0], mosi_log[1], mosi_log[2], mosi_log[3],
                                        mosi_log[4], mosi_log[5]}, 48'h51_00_00_00_A5_FF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
